npc_bp: RTL and testbench

- Parametrised next-PC generator for the 5-stage pipeline.
- Owns the fetch PC register and predicts next-PC in IF from a direct-mapped BTB with 2-bit saturating counters.
- Resolves branch, jal and jalr in EX using EX's own PC, so no stage-offset correction is needed.
- On misprediction, raises flush and redirects fetch on the next edge.

---
 rtl/npc_bp.sv | 224 ++++++++++++++++++++++
 tb/tb_npc_bp.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_bp.sv
// -----------------------------------------------------------------------------
// npc_bp : next-PC generator with a direct-mapped branch target buffer
//
// Owns the fetch PC register. Each cycle the BTB is looked up with the current
// fetch PC to produce a next-PC prediction. Control-transfer instructions are
// resolved in EX using the EX instruction's own PC. A misprediction raises
// flush for one cycle and redirects fetch on the following edge. The BTB holds
// one entry per index, each with a 2-bit saturating direction counter and a
// flag marking unconditional jumps.
//
// Ports
//   cpu_clk         clock, all state updates on the rising edge
//   cpu_rst         synchronous active-high reset
//   stall           hold the fetch PC (ignored when flush is raised)
//   if_pc           current fetch PC (registered)
//   if_pc4          if_pc + 4
//   if_pred_taken   BTB prediction for if_pc
//   if_pred_target  predicted next PC (if_pc + 4 on a BTB miss)
//   ex_valid        EX holds a real instruction
//   ex_pc           PC of the EX instruction
//   ex_op           00 sequential, 01 jalr, 10 branch, 11 jal
//   ex_br           branch condition (only for ex_op = 10)
//   ex_offset       sign-extended branch/jal immediate
//   ex_rs_imm       jalr target computed by the ALU
//   ex_pred_taken   prediction made at fetch for the EX instruction
//   ex_pred_target  predicted target made at fetch for the EX instruction
//   flush           misprediction, kills IF/ID this cycle
// -----------------------------------------------------------------------------
module npc_bp #(
   parameter int              XLEN        = 32,
   parameter int              BTB_ENTRIES = 16,
   parameter logic [XLEN-1:0] RESET_PC    = '0
) (
   input  logic            cpu_clk,
   input  logic            cpu_rst,
   input  logic            stall,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_pc4,
   output logic            if_pred_taken,
   output logic [XLEN-1:0] if_pred_target,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [1:0]      ex_op,
   input  logic            ex_br,
   input  logic [XLEN-1:0] ex_offset,
   input  logic [XLEN-1:0] ex_rs_imm,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic            flush
);

   localparam int IDX   = $clog2(BTB_ENTRIES);
   localparam int TAG_W = XLEN - IDX - 2;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   typedef enum logic [1:0] {
      OP_SEQ  = 2'b00,
      OP_JALR = 2'b01,
      OP_BR   = 2'b10,
      OP_JAL  = 2'b11
   } ex_op_e;

   // fetch PC
   logic [XLEN-1:0] pc_q, pc_d;

   // BTB storage
   logic             btb_valid_q  [BTB_ENTRIES];
   logic             btb_valid_d  [BTB_ENTRIES];
   logic [TAG_W-1:0] btb_tag_q    [BTB_ENTRIES];
   logic [TAG_W-1:0] btb_tag_d    [BTB_ENTRIES];
   logic [XLEN-1:0]  btb_target_q [BTB_ENTRIES];
   logic [XLEN-1:0]  btb_target_d [BTB_ENTRIES];
   logic [1:0]       btb_cnt_q    [BTB_ENTRIES];
   logic [1:0]       btb_cnt_d    [BTB_ENTRIES];
   logic             btb_jmp_q    [BTB_ENTRIES];
   logic             btb_jmp_d    [BTB_ENTRIES];

   // lookup side
   logic [IDX-1:0]   lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic [XLEN-1:0]  pc_plus4;

   // resolve side
   logic             act_taken;
   logic [XLEN-1:0]  act_target;
   logic             mispredict;
   logic [IDX-1:0]   up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;
   logic             up_en;
   logic             up_jmp;

   // ---------------------------------------------------------------------------
   // Fetch-side lookup. Reads only the registered BTB, so an update landing on
   // the same index this cycle is not visible until the next cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      lk_idx         = pc_q[IDX+1:2];
      lk_tag         = pc_q[XLEN-1:IDX+2];
      pc_plus4       = pc_q + PC_STEP;
      lk_hit         = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
      if_pred_taken  = lk_hit && (btb_jmp_q[lk_idx] || btb_cnt_q[lk_idx][1]);
      if_pred_target = lk_hit ? btb_target_q[lk_idx] : pc_plus4;
   end

   assign if_pc  = pc_q;
   assign if_pc4 = pc_plus4;

   // ---------------------------------------------------------------------------
   // Actual outcome of the EX instruction. A not-taken branch and a plain
   // sequential instruction both fall through to ex_pc + 4.
   // ---------------------------------------------------------------------------
   always_comb begin
      act_taken  = 1'b0;
      act_target = ex_pc + PC_STEP;
      case (ex_op)
         OP_JALR: begin
            act_taken  = 1'b1;
            act_target = ex_rs_imm;
         end
         OP_BR: begin
            if (ex_br) begin
               act_taken  = 1'b1;
               act_target = ex_pc + ex_offset;
            end
         end
         OP_JAL: begin
            act_taken  = 1'b1;
            act_target = ex_pc + ex_offset;
         end
         default: ;
      endcase
   end

   // A predicted target only matters when the instruction really is taken;
   // a correctly predicted not-taken branch never flushes.
   always_comb begin
      mispredict = (act_taken != ex_pred_taken) ||
                   (act_taken && (ex_pred_target != act_target));
      flush      = !cpu_rst && ex_valid && mispredict;
   end

   // ---------------------------------------------------------------------------
   // Next fetch PC. A redirect from EX outranks a stall since the instruction
   // being held is on the wrong path anyway.
   // ---------------------------------------------------------------------------
   always_comb begin
      if (flush) begin
         pc_d = act_target;
      end else if (stall) begin
         pc_d = pc_q;
      end else begin
         pc_d = if_pred_taken ? if_pred_target : pc_plus4;
      end
   end

   // ---------------------------------------------------------------------------
   // BTB update from EX. Sequential instructions never write, even when they
   // were mispredicted through aliasing; a missing entry is only allocated for
   // a taken transfer. Updates proceed regardless of stall.
   // ---------------------------------------------------------------------------
   always_comb begin
      up_idx = ex_pc[IDX+1:2];
      up_tag = ex_pc[XLEN-1:IDX+2];
      up_hit = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);
      up_en  = ex_valid && (ex_op != OP_SEQ) && !cpu_rst;
      up_jmp = (ex_op != OP_BR);

      btb_valid_d  = btb_valid_q;
      btb_tag_d    = btb_tag_q;
      btb_target_d = btb_target_q;
      btb_cnt_d    = btb_cnt_q;
      btb_jmp_d    = btb_jmp_q;

      if (up_en) begin
         if (up_hit) begin
            if (act_taken) begin
               if (btb_cnt_q[up_idx] != 2'b11) begin
                  btb_cnt_d[up_idx] = btb_cnt_q[up_idx] + 2'b01;
               end
               btb_target_d[up_idx] = act_target;
            end else if (btb_cnt_q[up_idx] != 2'b00) begin
               btb_cnt_d[up_idx] = btb_cnt_q[up_idx] - 2'b01;
            end
            btb_jmp_d[up_idx] = up_jmp;
         end else if (act_taken) begin
            btb_valid_d[up_idx]  = 1'b1;
            btb_tag_d[up_idx]    = up_tag;
            btb_target_d[up_idx] = act_target;
            btb_cnt_d[up_idx]    = 2'b10;
            btb_jmp_d[up_idx]    = up_jmp;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State with reset: fetch PC, valid bits and direction counters.
   // ---------------------------------------------------------------------------
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         pc_q <= RESET_PC;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid_q[i] <= 1'b0;
            btb_cnt_q[i]   <= 2'b00;
         end
      end else begin
         pc_q        <= pc_d;
         btb_valid_q <= btb_valid_d;
         btb_cnt_q   <= btb_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Payload fields need no reset: they are ignored while the valid bit is
   // clear, and the update enable is already suppressed during reset.
   // ---------------------------------------------------------------------------
   always_ff @(posedge cpu_clk) begin
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
      btb_jmp_q    <= btb_jmp_d;
   end

endmodule

// File: tb/tb_npc_bp.sv
// -----------------------------------------------------------------------------
// tb_npc_bp : self-checking bench for npc_bp (XLEN=32, BTB_ENTRIES=16)
//
// Directed scenarios exercise reset, cold allocation, counter hysteresis,
// jalr retargeting, stall/flush priority, aliasing and reset during a
// redirect. A randomized run compares every output each cycle with a
// behavioural model that tracks the fetch PC and a table of BTB entries.
// -----------------------------------------------------------------------------
module tb_npc_bp;

   localparam int          XLEN     = 32;
   localparam int          ENTRIES  = 16;
   localparam logic [31:0] RST_PC   = 32'h0000_0000;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic        stall;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;
   logic        if_pred_taken;
   logic [31:0] if_pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [1:0]  ex_op;
   logic        ex_br;
   logic [31:0] ex_offset;
   logic [31:0] ex_rs_imm;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        flush;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   logic [31:0] m_pc;
   bit          m_valid  [ENTRIES];
   logic [31:0] m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_cnt    [ENTRIES];
   bit          m_jmp    [ENTRIES];

   npc_bp #(
      .XLEN        (XLEN),
      .BTB_ENTRIES (ENTRIES),
      .RESET_PC    (RST_PC)
   ) dut (
      .cpu_clk        (cpu_clk),
      .cpu_rst        (cpu_rst),
      .stall          (stall),
      .if_pc          (if_pc),
      .if_pc4         (if_pc4),
      .if_pred_taken  (if_pred_taken),
      .if_pred_target (if_pred_target),
      .ex_valid       (ex_valid),
      .ex_pc          (ex_pc),
      .ex_op          (ex_op),
      .ex_br          (ex_br),
      .ex_offset      (ex_offset),
      .ex_rs_imm      (ex_rs_imm),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .flush          (flush)
   );

   always #5 cpu_clk = ~cpu_clk;

   // model: BTB slot and tag come from plain division of the address
   function automatic int m_slot(input logic [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic void m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
      int  s;
      bit  hit;
      s   = m_slot(pc);
      hit = m_valid[s] && (m_tag[s] == pc / (4 * ENTRIES));
      tk  = hit && (m_jmp[s] || m_cnt[s] >= 2);
      tg  = hit ? m_target[s] : pc + 32'd4;
   endfunction

   function automatic void m_resolve(output logic tk, output logic [31:0] tg, output logic fl);
      tk = 1'b0;
      tg = ex_pc + 32'd4;
      if (ex_op == 2'b01) begin
         tk = 1'b1;
         tg = ex_rs_imm;
      end else if (ex_op == 2'b11 || (ex_op == 2'b10 && ex_br)) begin
         tk = 1'b1;
         tg = ex_pc + ex_offset;
      end
      fl = !cpu_rst && ex_valid && ((tk != ex_pred_taken) || (tk && ex_pred_target != tg));
   endfunction

   // model: advance one clock edge using the inputs present before the edge
   task automatic m_edge();
      logic        ptk, atk, fl;
      logic [31:0] ptg, atg;
      int          s;
      bit          hit;
      m_lookup(m_pc, ptk, ptg);
      m_resolve(atk, atg, fl);
      if (cpu_rst) begin
         m_pc = RST_PC;
         for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_cnt[i]   = 0;
         end
      end else begin
         if (fl) m_pc = atg;
         else if (!stall) m_pc = ptk ? ptg : m_pc + 32'd4;
         if (ex_valid && ex_op != 2'b00) begin
            s   = m_slot(ex_pc);
            hit = m_valid[s] && (m_tag[s] == ex_pc / (4 * ENTRIES));
            if (hit) begin
               m_cnt[s] = atk ? ((m_cnt[s] < 3) ? m_cnt[s] + 1 : 3)
                              : ((m_cnt[s] > 0) ? m_cnt[s] - 1 : 0);
               if (atk) m_target[s] = atg;
               m_jmp[s] = (ex_op != 2'b10);
            end else if (atk) begin
               m_valid[s]  = 1;
               m_tag[s]    = ex_pc / (4 * ENTRIES);
               m_target[s] = atg;
               m_cnt[s]    = 2;
               m_jmp[s]    = (ex_op != 2'b10);
            end
         end
      end
   endtask

   task automatic clk_edge();
      @(posedge cpu_clk);
      m_edge();
      #1;
   endtask

   task automatic set_ex(input logic v, input logic [31:0] pc, input logic [1:0] op, input logic br,
                         input logic [31:0] off, input logic [31:0] rs,
                         input logic ptk, input logic [31:0] ptg);
      ex_valid       = v;
      ex_pc          = pc;
      ex_op          = op;
      ex_br          = br;
      ex_offset      = off;
      ex_rs_imm      = rs;
      ex_pred_taken  = ptk;
      ex_pred_target = ptg;
   endtask

   task automatic idle_ex();
      set_ex(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      cpu_rst = 1'b1;
      stall   = 1'b0;
      idle_ex();
      clk_edge();
      cpu_rst = 1'b0;
   endtask

   // reset values and three free-running fetch cycles
   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge cpu_clk);
         n_tests++;
         if (if_pc !== 32'(4 * i)) begin
            n_fail++;
            $display("[TB] FAIL reset_pc%0d: got %h want %h", i, if_pc, 32'(4 * i));
         end
         n_tests++;
         if (if_pred_taken !== 1'b0 || flush !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_pred%0d: got taken=%b flush=%b want 0/0", i, if_pred_taken, flush);
         end
         if (i == 0) begin
            n_tests++;
            if (if_pc4 !== 32'h4 || if_pred_target !== 32'h4) begin
               n_fail++;
               $display("[TB] FAIL reset_pc4: got pc4=%h tgt=%h want 4/4", if_pc4, if_pred_target);
            end
         end
         clk_edge();
      end
   endtask

   // first taken branch allocates, later fetch predicts it
   task automatic test_cold_branch();
      do_reset();
      set_ex(1'b1, 32'h10, 2'b10, 1'b1, 32'h20, 32'h0, 1'b0, 32'h14);
      @(negedge cpu_clk);
      n_tests++;
      if (flush !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL cold_flush: got %b want 1", flush);
      end
      clk_edge();
      idle_ex();
      @(negedge cpu_clk);
      n_tests++;
      if (if_pc !== 32'h30) begin
         n_fail++;
         $display("[TB] FAIL cold_redirect: got %h want 30", if_pc);
      end
      n_tests++;
      if (dut.btb_valid_q[4] !== 1'b1 || dut.btb_cnt_q[4] !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL cold_alloc: got v=%b cnt=%b want 1/10", dut.btb_valid_q[4], dut.btb_cnt_q[4]);
      end
      // aliased non-CTI redirect brings fetch back to 0x10 without a BTB write
      set_ex(1'b1, 32'hC, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 32'h99);
      clk_edge();
      idle_ex();
      @(negedge cpu_clk);
      n_tests++;
      if (if_pc !== 32'h10 || if_pred_taken !== 1'b1 || if_pred_target !== 32'h30) begin
         n_fail++;
         $display("[TB] FAIL cold_predict: got pc=%h tk=%b tgt=%h want 10/1/30", if_pc, if_pred_taken, if_pred_target);
      end
      set_ex(1'b1, 32'h10, 2'b10, 1'b1, 32'h20, 32'h0, 1'b1, 32'h30);
      @(negedge cpu_clk);
      n_tests++;
      if (flush !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL cold_noflush: got %b want 0", flush);
      end
      clk_edge();
      idle_ex();
   endtask

   // counter moves 10 -> 01 -> 00 then saturates at 11
   task automatic test_hysteresis();
      int exp_cnt [4] = '{1, 2, 3, 3};
      do_reset();
      set_ex(1'b1, 32'h10, 2'b10, 1'b1, 32'h20, 32'h0, 1'b0, 32'h14);
      clk_edge();
      set_ex(1'b1, 32'h10, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'h30);
      @(negedge cpu_clk);
      n_tests++;
      if (flush !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL hyst_flush1: got %b want 1", flush);
      end
      clk_edge();
      idle_ex();
      @(negedge cpu_clk);
      n_tests++;
      if (if_pc !== 32'h14 || dut.btb_cnt_q[4] !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL hyst_nt1: got pc=%h cnt=%b want 14/01", if_pc, dut.btb_cnt_q[4]);
      end
      set_ex(1'b1, 32'h10, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h14);
      @(negedge cpu_clk);
      n_tests++;
      if (flush !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL hyst_flush2: got %b want 0", flush);
      end
      clk_edge();
      idle_ex();
      @(negedge cpu_clk);
      n_tests++;
      if (dut.btb_cnt_q[4] !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL hyst_nt2: got cnt=%b want 00", dut.btb_cnt_q[4]);
      end
      for (int k = 0; k < 4; k++) begin
         set_ex(1'b1, 32'h10, 2'b10, 1'b1, 32'h20, 32'h0, 1'b0, 32'h14);
         clk_edge();
         idle_ex();
         @(negedge cpu_clk);
         n_tests++;
         if (dut.btb_cnt_q[4] !== 2'(exp_cnt[k])) begin
            n_fail++;
            $display("[TB] FAIL hyst_taken%0d: got cnt=%b want %0d", k, dut.btb_cnt_q[4], exp_cnt[k]);
         end
      end
   endtask

   // jalr changing target retrains the stored target
   task automatic test_jalr();
      do_reset();
      set_ex(1'b1, 32'h40, 2'b01, 1'b0, 32'h0, 32'h100, 1'b0, 32'h44);
      clk_edge();
      set_ex(1'b1, 32'h40, 2'b01, 1'b0, 32'h0, 32'h200, 1'b1, 32'h100);
      @(negedge cpu_clk);
      n_tests++;
      if (flush !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL jalr_flush: got %b want 1", flush);
      end
      clk_edge();
      idle_ex();
      @(negedge cpu_clk);
      n_tests++;
      if (if_pc !== 32'h200) begin
         n_fail++;
         $display("[TB] FAIL jalr_redirect: got %h want 200", if_pc);
      end
      n_tests++;
      if (dut.btb_target_q[0] !== 32'h200 || dut.btb_jmp_q[0] !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL jalr_entry: got tgt=%h jmp=%b want 200/1", dut.btb_target_q[0], dut.btb_jmp_q[0]);
      end
   endtask

   // flush overrides stall; plain stall holds the PC
   task automatic test_stall();
      do_reset();
      stall = 1'b1;
      set_ex(1'b1, 32'h60, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0, 32'h64);
      clk_edge();
      idle_ex();
      @(negedge cpu_clk);
      n_tests++;
      if (if_pc !== 32'h80) begin
         n_fail++;
         $display("[TB] FAIL stall_flush: got %h want 80", if_pc);
      end
      for (int k = 0; k < 3; k++) begin
         clk_edge();
         @(negedge cpu_clk);
         n_tests++;
         if (if_pc !== 32'h80) begin
            n_fail++;
            $display("[TB] FAIL stall_hold%0d: got %h want 80", k, if_pc);
         end
      end
      stall = 1'b0;
   endtask

   // index aliasing, aliased non-CTI, reset during redirect
   task automatic test_alias();
      int nvalid;
      do_reset();
      set_ex(1'b1, 32'h10, 2'b10, 1'b1, 32'h20, 32'h0, 1'b0, 32'h14);
      clk_edge();
      set_ex(1'b1, 32'h4C, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 32'h30);
      clk_edge();
      idle_ex();
      @(negedge cpu_clk);
      n_tests++;
      if (if_pc !== 32'h50 || if_pred_taken !== 1'b0 || if_pred_target !== 32'h54) begin
         n_fail++;
         $display("[TB] FAIL alias_lookup: got pc=%h tk=%b tgt=%h want 50/0/54", if_pc, if_pred_taken, if_pred_target);
      end
      set_ex(1'b1, 32'h50, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 32'h30);
      @(negedge cpu_clk);
      n_tests++;
      if (flush !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL alias_flush: got %b want 1", flush);
      end
      clk_edge();
      idle_ex();
      @(negedge cpu_clk);
      n_tests++;
      if (if_pc !== 32'h54 || dut.btb_valid_q[4] !== 1'b1 || dut.btb_tag_q[4] !== '0 || dut.btb_cnt_q[4] !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL alias_nowrite: got pc=%h v=%b cnt=%b want 54/1/10", if_pc, dut.btb_valid_q[4], dut.btb_cnt_q[4]);
      end
      set_ex(1'b1, 32'h70, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0, 32'h74);
      cpu_rst = 1'b1;
      @(negedge cpu_clk);
      n_tests++;
      if (flush !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rst_flush: got %b want 0", flush);
      end
      clk_edge();
      cpu_rst = 1'b0;
      idle_ex();
      @(negedge cpu_clk);
      nvalid = 0;
      for (int i = 0; i < ENTRIES; i++) if (dut.btb_valid_q[i] !== 1'b0) nvalid++;
      n_tests++;
      if (if_pc !== RST_PC || nvalid != 0) begin
         n_fail++;
         $display("[TB] FAIL rst_redirect: got pc=%h valid_entries=%0d want %h/0", if_pc, nvalid, RST_PC);
      end
   endtask

   // randomized traffic against the model
   task automatic test_random();
      logic        etk, efl, atk;
      logic [31:0] etg, atg, mtg;
      logic        mtk;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         cpu_rst  = ($urandom_range(0, 59) == 0);
         stall    = ($urandom_range(0, 3) == 0);
         ex_valid = ($urandom_range(0, 3) != 0);
         ex_pc    = 32'($urandom_range(0, 63)) << 2;
         ex_op    = 2'($urandom_range(0, 3));
         ex_br    = 1'($urandom_range(0, 1));
         ex_offset = (32'($urandom_range(0, 63)) << 2) - 32'd128;
         ex_rs_imm = 32'($urandom_range(0, 63)) << 2;
         if ($urandom_range(0, 1) == 1) begin
            m_lookup(ex_pc, mtk, mtg);
            ex_pred_taken  = mtk;
            ex_pred_target = mtg;
         end else begin
            ex_pred_taken  = 1'($urandom_range(0, 1));
            ex_pred_target = 32'($urandom_range(0, 63)) << 2;
         end
         @(negedge cpu_clk);
         m_lookup(m_pc, etk, etg);
         m_resolve(atk, atg, efl);
         n_tests++;
         if (if_pc !== m_pc || if_pc4 !== m_pc + 32'd4) begin
            n_fail++;
            $display("[TB] FAIL rand_pc@%0d: got %h/%h want %h", c, if_pc, if_pc4, m_pc);
         end
         n_tests++;
         if (if_pred_taken !== etk || if_pred_target !== etg) begin
            n_fail++;
            $display("[TB] FAIL rand_pred@%0d: got %b/%h want %b/%h", c, if_pred_taken, if_pred_target, etk, etg);
         end
         n_tests++;
         if (flush !== efl) begin
            n_fail++;
            $display("[TB] FAIL rand_flush@%0d: got %b want %b (target %h)", c, flush, efl, atg);
         end
         clk_edge();
      end
      cpu_rst = 1'b0;
      stall   = 1'b0;
      idle_ex();
   endtask

   initial begin
      cpu_rst = 1'b1;
      stall   = 1'b0;
      idle_ex();
      m_pc = RST_PC;
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i]  = 0;
         m_tag[i]    = '0;
         m_target[i] = '0;
         m_cnt[i]    = 0;
         m_jmp[i]    = 0;
      end
      #1;
      test_reset();
      test_cold_branch();
      test_hysteresis();
      test_jalr();
      test_stall();
      test_alias();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
